gen_data_param: RTL

- Parametrised successor to the fixed 256-bit DDR3 write-data generator.
- Produces a programmable-length run of test words into the DDR3 write-side FIFO, one word per accepted cycle.
- Selectable pattern mode, throttled by FIFO full; reports busy/done to the test controller.
- Sits between the test controller and the write FIFO in the ui_clk domain.

---
 rtl/gen_data_pkg.sv | 37 +++
 rtl/gen_data_if.sv | 11 +
 rtl/gen_data_pattern.sv | 42 ++++
 rtl/gen_data_param.sv | 126 ++++++++++++
 4 files changed

// File: rtl/gen_data_pkg.sv
// Shared definitions for the DDR3 write-data generator: pattern modes, FSM states,
// PRBS taps and small helpers used by both the top and the pattern function.
package gen_data_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_PRBS  = 2'd1,
    MODE_WALK1 = 2'd2,
    MODE_ALT   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FILL,
    ST_DONE
  } state_e;

  // x^32 + x^22 + x^2 + x + 1, expressed as state bit positions
  localparam int unsigned PRBS_TAP_A = 31;
  localparam int unsigned PRBS_TAP_B = 21;
  localparam int unsigned PRBS_TAP_C = 1;
  localparam int unsigned PRBS_TAP_D = 0;

  localparam logic [31:0] DEFAULT_SEED = 32'h1;

  function automatic logic [31:0] prbs_next(input logic [31:0] s);
    return {s[30:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B] ^ s[PRBS_TAP_C] ^ s[PRBS_TAP_D]};
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] n);
    logic [63:0] d;
    d = {v, v} << n;
    return d[63:32];
  endfunction

endpackage

// File: rtl/gen_data_if.sv
// Write-side FIFO bus: the generator (master) pushes words, the FIFO (slave) backpressures.
interface gen_data_if #(
  parameter int DATA_W = 256
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;

  modport master (output wr_en, output wr_data, input full);
  modport slave  (input wr_en, input wr_data, output full);
endinterface

// File: rtl/gen_data_pattern.sv
// Combinational test-word function: returns word k of the selected pattern,
// given the latched seed and the PRBS state that belongs to word k.
module gen_data_pattern
  import gen_data_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int LANE_W = 32,
  parameter int LANES  = DATA_W / LANE_W,
  parameter int CNT_W  = 16
) (
  input  mode_e              mode,
  input  logic [CNT_W-1:0]   k,
  input  logic [31:0]        seed,
  input  logic [31:0]        lfsr,
  output logic [DATA_W-1:0]  word
);

  logic [31:0] k_ext;
  logic [31:0] incr_base;
  logic [31:0] walk_pos;

  assign k_ext     = 32'(k);
  assign incr_base = seed + k_ext * 32'(LANES);
  assign walk_pos  = k_ext % 32'(DATA_W);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    word = '0;
    case (mode)
      MODE_INCR: begin
        for (int j = 0; j < LANES; j++) word[j*LANE_W +: LANE_W] = incr_base + 32'(j);
      end
      MODE_PRBS: begin
        for (int j = 0; j < LANES; j++) word[j*LANE_W +: LANE_W] = rotl32(lfsr, 5'(j));
      end
      MODE_WALK1: word = {{(DATA_W-1){1'b0}}, 1'b1} << walk_pos;
      MODE_ALT:   word = {LANES{k[0] ? ~seed : seed}};
      default:    word = '0;
    endcase
  end

endmodule

// File: rtl/gen_data_param.sv
// Parametrised DDR3 write-data generator: runs num_words pattern words into the
// write FIFO, one per non-full cycle, and reports busy/done to the test controller.
module gen_data_param
  import gen_data_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int LANE_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             ui_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_words,
  input  logic [31:0]      seed,
  gen_data_if.master       fifo,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_written
);

  localparam int LANES = DATA_W / LANE_W;

  state_e            state, state_nxt;
  mode_e             mode_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  k_q;
  logic [31:0]       seed_q;
  logic [31:0]       lfsr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic [CNT_W-1:0]  pat_k;
  logic [31:0]       pat_lfsr;
  logic [DATA_W-1:0] pat_word;
  logic              wr_fire;
  logic              last_word;

  assign wr_fire      = (state == ST_FILL) && !fifo.full;
  assign last_word    = (k_q == num_q - CNT_W'(1));
  assign fifo.wr_en   = wr_fire;
  assign fifo.wr_data = wr_data_q;

  // LOAD prepares word 0; FILL prepares word k+1 so it is ready the cycle after a write.
  always_comb begin
    pat_k    = '0;
    pat_lfsr = seed_q;
    if (state == ST_FILL) begin
      pat_k    = k_q + CNT_W'(1);
      pat_lfsr = prbs_next(lfsr_q);
    end
  end

  gen_data_pattern #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W),
    .LANES  (LANES),
    .CNT_W  (CNT_W)
  ) u_pattern (
    .mode (mode_q),
    .k    (pat_k),
    .seed (seed_q),
    .lfsr (pat_lfsr),
    .word (pat_word)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge ui_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = (num_q == '0) ? ST_DONE : ST_FILL;
      ST_FILL: if (wr_fire && last_word) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_LOAD) || (state == ST_FILL);
    done = (state == ST_DONE);
  end

  always_ff @(posedge ui_clk) begin
    if (rst) begin
      mode_q        <= MODE_INCR;
      num_q         <= '0;
      seed_q        <= '0;
      k_q           <= '0;
      lfsr_q        <= '0;
      wr_data_q     <= '0;
      words_written <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q <= mode_e'(mode);
            num_q  <= num_words;
            // an all-zero LFSR would lock up, so PRBS falls back to a known seed
            seed_q <= (mode_e'(mode) == MODE_PRBS && seed == '0) ? DEFAULT_SEED : seed;
          end
        end
        ST_LOAD: begin
          words_written <= '0;
          k_q           <= '0;
          lfsr_q        <= seed_q;
          wr_data_q     <= pat_word;
        end
        ST_FILL: begin
          if (wr_fire) begin
            words_written <= words_written + CNT_W'(1);
            k_q           <= k_q + CNT_W'(1);
            lfsr_q        <= pat_lfsr;
            wr_data_q     <= pat_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
